stream_pending_tracker: RTL and testbench

Tracks outstanding ready/valid transfers in order, from issue to response, and tags each response with the ID of the request that caused it. It sits on the request path directly downstream of the stream throttle stage. It records an ID on every accepted request and pops it when the matching response is handshaked. Its pending count and full status form the credit information that the throttle stage consumes.

---
 rtl/stream_pending_tracker_if.sv | 35 +++
 rtl/stream_pending_tracker.sv | 77 +++++++
 tb/tb_stream_pending_tracker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/stream_pending_tracker_if.sv
// Handshake bundle for stream_pending_tracker. Signal directions are named from the tracker's side.
// The tracker uses the slave modport, and the agent driving it uses the master modport.
interface stream_pending_tracker_if #(
  parameter int unsigned MaxNumPending = 4,
  parameter int unsigned IdWidth       = 4
);
  localparam int unsigned CntWidth = $clog2(MaxNumPending + 1);

  logic                req_valid_i;
  logic                req_ready_o;
  logic [IdWidth-1:0]  req_id_i;
  logic                req_valid_o;
  logic                req_ready_i;
  logic                rsp_valid_i;
  logic                rsp_ready_o;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [IdWidth-1:0]  rsp_id_o;
  logic [CntWidth-1:0] pending_o;
  logic                full_o;
  logic                empty_o;
  logic                err_o;

  modport slave (
    input  req_valid_i, req_id_i, req_ready_i, rsp_valid_i, rsp_ready_i,
    output req_ready_o, req_valid_o, rsp_ready_o, rsp_valid_o, rsp_id_o,
           pending_o, full_o, empty_o, err_o
  );

  modport master (
    output req_valid_i, req_id_i, req_ready_i, rsp_valid_i, rsp_ready_i,
    input  req_ready_o, req_valid_o, rsp_ready_o, rsp_valid_o, rsp_id_o,
           pending_o, full_o, empty_o, err_o
  );
endinterface

// File: rtl/stream_pending_tracker.sv
// In-order outstanding-transfer tracker. It records the ID of each accepted request and
// returns the oldest ID with each response. Its pending count and full flag form credit information.
module stream_pending_tracker #(
  parameter int unsigned MaxNumPending = 4,
  parameter int unsigned IdWidth       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  stream_pending_tracker_if.slave bus
);
  localparam int unsigned CntWidth = $clog2(MaxNumPending + 1);
  localparam int unsigned PtrWidth = (MaxNumPending > 1) ? $clog2(MaxNumPending) : 1;
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxNumPending);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MaxNumPending - 1);

  logic [IdWidth-1:0]  id_mem_q [MaxNumPending];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                full, empty, push, pop;

  // Wrap by explicit compare, so non-power-of-2 depths never index past the store.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full  = (cnt_q == CntMax);
  assign empty = (cnt_q == '0);
  assign push  = bus.req_valid_i & bus.req_ready_i & ~full;
  assign pop   = bus.rsp_valid_i & bus.rsp_ready_i & ~empty;

  assign bus.req_valid_o = bus.req_valid_i & ~full;
  assign bus.req_ready_o = bus.req_ready_i & ~full;
  // While empty, a stray response is accepted and dropped, so it cannot stall downstream.
  assign bus.rsp_valid_o = bus.rsp_valid_i & ~empty;
  assign bus.rsp_ready_o = empty | bus.rsp_ready_i;
  assign bus.rsp_id_o    = id_mem_q[rd_ptr_q];
  assign bus.pending_o   = cnt_q;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.err_o       = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
    if (bus.rsp_valid_i && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // The ID store is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wr_ptr_q] <= bus.req_id_i;
  end
endmodule

// File: tb/tb_stream_pending_tracker.sv
// Directed bench for stream_pending_tracker at depth 4 and depth 3, with an in-order ID scoreboard.
module tb_stream_pending_tracker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stream_pending_tracker_if #(.MaxNumPending(4), .IdWidth(4)) if4 ();
  stream_pending_tracker_if #(.MaxNumPending(3), .IdWidth(4)) if3 ();

  stream_pending_tracker #(.MaxNumPending(4), .IdWidth(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(if4));
  stream_pending_tracker #(.MaxNumPending(3), .IdWidth(4)) dut3 (.clk_i(clk), .rst_i(rst), .bus(if3));

  typedef struct {
    logic        rvo, rro, svo, sro, full, empty, err;
    logic [3:0]  rid;
    logic [31:0] pend;
  } obs_t;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] mq[$];
  int         m_max = 4;
  bit         m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit rv, input logic [3:0] id, input bit rr,
                       input bit sv, input bit sr);
    if (sel == 4) begin
      if4.req_valid_i = rv; if4.req_id_i = id; if4.req_ready_i = rr;
      if4.rsp_valid_i = sv; if4.rsp_ready_i = sr;
    end else begin
      if3.req_valid_i = rv; if3.req_id_i = id; if3.req_ready_i = rr;
      if3.rsp_valid_i = sv; if3.rsp_ready_i = sr;
    end
  endtask

  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 4) begin
      o.rvo = if4.req_valid_o; o.rro = if4.req_ready_o; o.svo = if4.rsp_valid_o;
      o.sro = if4.rsp_ready_o; o.full = if4.full_o; o.empty = if4.empty_o;
      o.err = if4.err_o; o.rid = if4.rsp_id_o; o.pend = 32'(if4.pending_o);
    end else begin
      o.rvo = if3.req_valid_o; o.rro = if3.req_ready_o; o.svo = if3.rsp_valid_o;
      o.sro = if3.rsp_ready_o; o.full = if3.full_o; o.empty = if3.empty_o;
      o.err = if3.err_o; o.rid = if3.rsp_id_o; o.pend = 32'(if3.pending_o);
    end
    return o;
  endfunction

  // One clock cycle: drive after the falling edge, check before the rising edge, and update the model.
  task automatic cycle(input int sel, input string tag, input bit rv, input logic [3:0] id,
                       input bit rr, input bit sv, input bit sr);
    obs_t o;
    bit ex_full, ex_empty, push, pop, e_rvo, e_rro, e_svo, e_sro;
    drive(sel, rv, id, rr, sv, sr);
    #1;
    o        = sample(sel);
    ex_full  = (mq.size() == m_max);
    ex_empty = (mq.size() == 0);
    push     = rv & rr & ~ex_full;
    pop      = sv & sr & ~ex_empty;
    e_rvo    = rv & ~ex_full;
    e_rro    = rr & ~ex_full;
    e_svo    = sv & ~ex_empty;
    e_sro    = ex_empty | sr;
    check({tag, ".req_valid_o"}, 32'(o.rvo),   32'(e_rvo));
    check({tag, ".req_ready_o"}, 32'(o.rro),   32'(e_rro));
    check({tag, ".rsp_valid_o"}, 32'(o.svo),   32'(e_svo));
    check({tag, ".rsp_ready_o"}, 32'(o.sro),   32'(e_sro));
    check({tag, ".pending_o"},   o.pend,       32'(mq.size()));
    check({tag, ".full_o"},      32'(o.full),  32'(ex_full));
    check({tag, ".empty_o"},     32'(o.empty), 32'(ex_empty));
    check({tag, ".err_o"},       32'(o.err),   32'(m_err));
    if (pop) begin
      check({tag, ".rsp_id_o"}, 32'(o.rid), 32'(mq[0]));
      void'(mq.pop_front());
    end
    if (sv && ex_empty) m_err = 1'b1;
    if (push) mq.push_back(id);
    @(negedge clk);
  endtask

  initial begin
    obs_t o;
    drive(4, 0, 4'h0, 0, 0, 0);
    drive(3, 0, 4'h0, 0, 0, 0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    o = sample(4);
    check("rst.pending_o",   o.pend,       32'd0);
    check("rst.empty_o",     32'(o.empty), 32'd1);
    check("rst.full_o",      32'(o.full),  32'd0);
    check("rst.err_o",       32'(o.err),   32'd0);
    check("rst.rsp_valid_o", 32'(o.svo),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fill then drain.
    cycle(4, "fill", 1, 4'd3, 1, 0, 0);
    cycle(4, "fill", 1, 4'd7, 1, 0, 0);
    cycle(4, "fill", 1, 4'd1, 1, 0, 0);
    cycle(4, "fill", 1, 4'd9, 1, 0, 0);
    cycle(4, "full_blk", 1, 4'hA, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(4, "drain", 0, 4'h0, 0, 1, 1);
    cycle(4, "drained", 0, 4'h0, 0, 0, 0);

    // Full with a simultaneous pop.
    for (int i = 0; i < 4; i++) cycle(4, "refill", 1, 4'(i + 4), 1, 0, 0);
    cycle(4, "full_pop", 1, 4'hB, 1, 1, 1);
    cycle(4, "full_retry", 1, 4'hB, 1, 0, 0);
    cycle(4, "full_again", 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(4, "drain2", 0, 4'h0, 0, 1, 1);

    // Steady stream at a depth of 2, which makes both pointers wrap repeatedly.
    cycle(4, "steady_pre", 1, 4'd0, 1, 0, 0);
    cycle(4, "steady_pre", 1, 4'd1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(4, "steady", 1, 4'(i + 2), 1, 1, 1);
    for (int i = 0; i < 2; i++) cycle(4, "steady_drain", 0, 4'h0, 0, 1, 1);

    // A stray response arrives while empty.
    cycle(4, "stray", 0, 4'h0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(4, "stray_hold", 0, 4'h0, 0, 0, 0);

    // Reset mid-operation while three entries are pending.
    cycle(4, "pre_rst", 1, 4'hB, 1, 0, 0);
    cycle(4, "pre_rst", 1, 4'hC, 1, 0, 0);
    cycle(4, "pre_rst", 1, 4'hD, 1, 0, 0);
    drive(4, 1, 4'h2, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    o = sample(4);
    check("midrst.pending_o",   o.pend,       32'd0);
    check("midrst.empty_o",     32'(o.empty), 32'd1);
    check("midrst.full_o",      32'(o.full),  32'd0);
    check("midrst.err_o",       32'(o.err),   32'd0);
    check("midrst.req_valid_o", 32'(o.rvo),   32'd1);
    check("midrst.req_ready_o", 32'(o.rro),   32'd1);
    mq.delete();
    m_err = 1'b0;
    @(negedge clk);
    drive(4, 0, 4'h0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    cycle(4, "post_rst", 1, 4'hE, 1, 0, 0);
    cycle(4, "post_rst", 0, 4'h0, 0, 1, 1);

    // Non-power-of-2 depth.
    m_max = 3;
    for (int i = 0; i < 3; i++) cycle(3, "np2_fill", 1, 4'(i), 1, 0, 0);
    cycle(3, "np2_blk", 1, 4'd3, 1, 0, 0);
    for (int i = 3; i < 10; i++) cycle(3, "np2_round", 1, 4'(i), 1, 1, 1);
    for (int i = 0; i < 3; i++) cycle(3, "np2_drain", 0, 4'h0, 0, 1, 1);
    cycle(3, "np2_done", 0, 4'h0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
